// File: rtl/muladd_pkg.sv
// Shared constants, saturation-limit helper and the width-check macro for muladd_pipe.
`ifndef MULADD_PKG_SV
`define MULADD_PKG_SV

// Elaboration guard: the accumulator must hold the full product without loss.
`define MULADD_WIDTH_CHECK(acc_w, prod_w) \
  if ((acc_w) < (prod_w)) begin : g_width_check \
    $error("muladd_pipe: ACC_WIDTH must be at least A_WIDTH+B_WIDTH"); \
  end

package muladd_pkg;

  // Selects the accumulate-stage addend: C for an add, Q for an accumulate.
  localparam logic ACC_MODE_ADD = 1'b0;
  localparam logic ACC_MODE_ACC = 1'b1;

  // Widest accumulator the saturation helper can describe.
  localparam int SAT_MAX_WIDTH = 64;

  // Largest or smallest representable value of a width-bit number.
  // The result is right-aligned in SAT_MAX_WIDTH bits; callers keep the low width bits.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_limit(input int width,
                                                         input bit is_signed,
                                                         input bit want_max);
    logic [SAT_MAX_WIDTH-1:0] ones;
    ones = '1;
    if (!is_signed) begin
      return want_max ? (ones >> (SAT_MAX_WIDTH - width)) : '0;
    end
    if (want_max) begin
      return ones >> (SAT_MAX_WIDTH - width + 1);
    end
    return ~(ones >> (SAT_MAX_WIDTH - width + 1));
  endfunction

endpackage

`endif

// File: rtl/muladd_sat_add.sv
// Accumulator adder: ACC_WIDTH add with overflow detection and optional clamping.
module muladd_sat_add
  import muladd_pkg::*;
#(
  parameter int ACC_WIDTH = 20,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 0
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 ovf_o
);

  localparam int MSB = ACC_WIDTH - 1;
  localparam logic [SAT_MAX_WIDTH-1:0] MAX_FULL = sat_limit(ACC_WIDTH, SIGNED != 0, 1'b1);
  localparam logic [SAT_MAX_WIDTH-1:0] MIN_FULL = sat_limit(ACC_WIDTH, SIGNED != 0, 1'b0);
  localparam logic [ACC_WIDTH-1:0]     SAT_MAX  = MAX_FULL[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0]     SAT_MIN  = MIN_FULL[ACC_WIDTH-1:0];

  logic [ACC_WIDTH:0] sum_wide;
  logic               ovf;

  // One extra bit of width gives the unsigned carry; signed overflow is a sign flip.
  always_comb begin
    sum_wide = {1'b0, a_i} + {1'b0, b_i};
    if (SIGNED != 0) begin
      ovf = (a_i[MSB] == b_i[MSB]) && (sum_wide[MSB] != a_i[MSB]);
    end else begin
      ovf = sum_wide[ACC_WIDTH];
    end
    sum_o = sum_wide[ACC_WIDTH-1:0];
    // Unsigned overflow can only go upward; signed direction follows the addends' sign.
    if (ovf && (SATURATE != 0)) begin
      sum_o = ((SIGNED != 0) && a_i[MSB]) ? SAT_MIN : SAT_MAX;
    end
    ovf_o = ovf;
  end

endmodule

// File: rtl/muladd_pipe.sv
// Pipelined multiply-add / MAC: optional input and product registers, then a registered
// accumulate stage with single-cycle feedback, valid tracking, clock enable and clear.
module muladd_pipe
  import muladd_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 20,
  parameter int IN_REG    = 1,
  parameter int MUL_REG   = 1,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 0
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 acc_en,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic [ACC_WIDTH-1:0] C,
  output logic [ACC_WIDTH-1:0] Q,
  output logic                 out_valid,
  output logic                 ovf
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  `MULADD_WIDTH_CHECK(ACC_WIDTH, P_WIDTH)

  // Stage 1: operands as seen by the multiplier.
  logic [A_WIDTH-1:0]   s1_a;
  logic [B_WIDTH-1:0]   s1_b;
  logic [ACC_WIDTH-1:0] s1_c;
  logic                 s1_acc;
  logic                 s1_vld;

  // Stage 2: product and its companions as seen by the accumulator.
  logic [P_WIDTH-1:0]   prod;
  logic [P_WIDTH-1:0]   s2_p;
  logic [ACC_WIDTH-1:0] s2_p_ext;
  logic [ACC_WIDTH-1:0] s2_c;
  logic                 s2_acc;
  logic                 s2_vld;

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic [A_WIDTH-1:0]   a_q;
      logic [B_WIDTH-1:0]   b_q;
      logic [ACC_WIDTH-1:0] c_q;
      logic                 acc_q;
      logic                 vld_q;

      // Input register; clear only kills the valid bit, data is don't-care when invalid.
      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= '0;
          acc_q <= 1'b0;
          vld_q <= 1'b0;
        end else if (clr) begin
          vld_q <= 1'b0;
        end else if (en) begin
          a_q   <= A;
          b_q   <= B;
          c_q   <= C;
          acc_q <= acc_en;
          vld_q <= in_valid;
        end
      end

      assign s1_a   = a_q;
      assign s1_b   = b_q;
      assign s1_c   = c_q;
      assign s1_acc = acc_q;
      assign s1_vld = vld_q;
    end else begin : g_in_bypass
      assign s1_a   = A;
      assign s1_b   = B;
      assign s1_c   = C;
      assign s1_acc = acc_en;
      assign s1_vld = in_valid;
    end
  endgenerate

  // Operands are widened to the full product width first so the multiply keeps every bit.
  generate
    if (SIGNED != 0) begin : g_mul_signed
      logic [P_WIDTH-1:0] a_ext;
      logic [P_WIDTH-1:0] b_ext;
      assign a_ext = {{B_WIDTH{s1_a[A_WIDTH-1]}}, s1_a};
      assign b_ext = {{A_WIDTH{s1_b[B_WIDTH-1]}}, s1_b};
      assign prod  = a_ext * b_ext;
    end else begin : g_mul_unsigned
      logic [P_WIDTH-1:0] a_ext;
      logic [P_WIDTH-1:0] b_ext;
      assign a_ext = {{B_WIDTH{1'b0}}, s1_a};
      assign b_ext = {{A_WIDTH{1'b0}}, s1_b};
      assign prod  = a_ext * b_ext;
    end
  endgenerate

  generate
    if (MUL_REG != 0) begin : g_mul_reg
      logic [P_WIDTH-1:0]   p_q;
      logic [ACC_WIDTH-1:0] c_q;
      logic                 acc_q;
      logic                 vld_q;

      // Product register, carrying C, acc_en and valid alongside the sample.
      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          p_q   <= '0;
          c_q   <= '0;
          acc_q <= 1'b0;
          vld_q <= 1'b0;
        end else if (clr) begin
          vld_q <= 1'b0;
        end else if (en) begin
          p_q   <= prod;
          c_q   <= s1_c;
          acc_q <= s1_acc;
          vld_q <= s1_vld;
        end
      end

      assign s2_p   = p_q;
      assign s2_c   = c_q;
      assign s2_acc = acc_q;
      assign s2_vld = vld_q;
    end else begin : g_mul_bypass
      assign s2_p   = prod;
      assign s2_c   = s1_c;
      assign s2_acc = s1_acc;
      assign s2_vld = s1_vld;
    end
  endgenerate

  // Extend the product to accumulator width according to the arithmetic mode.
  generate
    if (SIGNED != 0) begin : g_ext_signed
      assign s2_p_ext = ACC_WIDTH'($signed(s2_p));
    end else begin : g_ext_unsigned
      assign s2_p_ext = ACC_WIDTH'(s2_p);
    end
  endgenerate

  // Accumulate stage state.
  logic [ACC_WIDTH-1:0] q_q;
  logic [ACC_WIDTH-1:0] q_d;
  logic                 out_valid_q;
  logic                 out_valid_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] sum;
  logic                 add_ovf;

  // Addend selection: feeding Q back directly keeps the accumulate loop single-cycle.
  always_comb begin
    addend = s2_c;
    case (s2_acc)
      ACC_MODE_ACC: addend = q_q;
      ACC_MODE_ADD: addend = s2_c;
      default:      addend = s2_c;
    endcase
  end

  muladd_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_sat_add (
    .a_i   (addend),
    .b_i   (s2_p_ext),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  // Next-state for Q, out_valid and sticky ovf; clear beats enable and the current sample.
  always_comb begin
    q_d         = q_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (clr) begin
      q_d         = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else if (en) begin
      if (s2_vld) begin
        q_d         = sum;
        out_valid_d = 1'b1;
        ovf_d       = ovf_q | add_ovf;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Accumulate-stage registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign Q         = q_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_muladd_pipe.sv
// Directed bench for muladd_pipe: default, saturating and signed/unpipelined instances
// share one stimulus stream; each check compares against hand-computed values.
module tb_muladd_pipe;

  logic        CLK;
  logic        rst_n;
  logic        clr;
  logic        en;
  logic        in_valid;
  logic        acc_en;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [19:0] C;

  logic [19:0] q_def, q_sat, q_sgn;
  logic        ov_def, ov_sat, ov_sgn;
  logic        ovf_def, ovf_sat, ovf_sgn;

  int n_checks;
  int n_pass;

  muladd_pipe dut (
    .CLK(CLK), .rst_n(rst_n), .clr(clr), .en(en), .in_valid(in_valid), .acc_en(acc_en),
    .A(A), .B(B), .C(C), .Q(q_def), .out_valid(ov_def), .ovf(ovf_def)
  );

  muladd_pipe #(.SATURATE(1)) dut_sat (
    .CLK(CLK), .rst_n(rst_n), .clr(clr), .en(en), .in_valid(in_valid), .acc_en(acc_en),
    .A(A), .B(B), .C(C), .Q(q_sat), .out_valid(ov_sat), .ovf(ovf_sat)
  );

  muladd_pipe #(.SIGNED(1), .IN_REG(0), .MUL_REG(0)) dut_sgn (
    .CLK(CLK), .rst_n(rst_n), .clr(clr), .en(en), .in_valid(in_valid), .acc_en(acc_en),
    .A(A), .B(B), .C(C), .Q(q_sgn), .out_valid(ov_sgn), .ovf(ovf_sgn)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
  endtask

  task automatic drive(input logic [7:0] a_v, input logic [7:0] b_v,
                       input logic [19:0] c_v, input logic acc_v);
    A        = a_v;
    B        = b_v;
    C        = c_v;
    acc_en   = acc_v;
    in_valid = 1'b1;
    $display("txn t=%0t A=0x%0h B=0x%0h C=0x%0h acc_en=%0b", $time, a_v, b_v, c_v, acc_v);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_en   = 1'b0;
    A        = '0;
    B        = '0;
    C        = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    en       = 1'b1;
    idle();
    cycle();
    cycle();
    check_val("reset_q", q_def, 0);
    check_val("reset_valid", ov_def, 0);
    check_val("reset_ovf", ovf_def, 0);
    rst_n = 1'b1;

    // Basic add, default latency 3; signed bypassed instance answers after 1 edge.
    drive(8'd3, 8'd5, 20'd7, 1'b0);
    cycle();
    check_val("sgn_lat1_valid", ov_sgn, 1);
    check_val("sgn_lat1_q", q_sgn, 22);
    check_val("lat_e1_valid", ov_def, 0);
    idle();
    cycle();
    check_val("lat_e2_valid", ov_def, 0);
    cycle();
    check_val("lat_e3_valid", ov_def, 1);
    check_val("lat_e3_q", q_def, 22);
    check_val("lat_e3_ovf", ovf_def, 0);
    cycle();
    check_val("lat_e4_valid", ov_def, 0);

    // Back-to-back accumulation: 100, 200, 300, 400 on consecutive cycles.
    do_clr();
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(8'd10, 8'd10, 20'd0, 1'b1);
      else idle();
      cycle();
      if (k >= 2 && k <= 5) begin
        check_val($sformatf("acc_valid_%0d", k), ov_def, 1);
        check_val($sformatf("acc_q_%0d", k), q_def, 32'(100 * (k - 1)));
      end else begin
        check_val($sformatf("acc_idle_%0d", k), ov_def, 0);
      end
    end

    // Two-cycle stall with a sample in the input register: result at edge 5.
    do_clr();
    drive(8'd3, 8'd5, 20'd7, 1'b0);
    cycle();
    idle();
    en = 1'b0;
    cycle();
    check_val("stall_e2_valid", ov_def, 0);
    cycle();
    check_val("stall_e3_valid", ov_def, 0);
    en = 1'b1;
    cycle();
    check_val("stall_e4_valid", ov_def, 0);
    cycle();
    check_val("stall_e5_valid", ov_def, 1);
    check_val("stall_e5_q", q_def, 22);
    cycle();
    check_val("stall_e6_valid", ov_def, 0);

    // Unsigned overflow: preload 0xFFFFF-100, then add 121.
    do_clr();
    drive(8'd0, 8'd0, 20'hFFF9B, 1'b0);
    cycle();
    drive(8'd11, 8'd11, 20'd0, 1'b1);
    cycle();
    drive(8'd1, 8'd1, 20'd0, 1'b0);
    cycle();
    check_val("pre_q", q_def, 32'hFFF9B);
    check_val("pre_ovf", ovf_def, 0);
    idle();
    cycle();
    check_val("wrap_q", q_def, 20);
    check_val("wrap_ovf", ovf_def, 1);
    check_val("sat_q", q_sat, 32'hFFFFF);
    check_val("sat_ovf", ovf_sat, 1);
    cycle();
    check_val("sticky_q", q_def, 1);
    check_val("sticky_ovf", ovf_def, 1);
    check_val("sat_sticky_q", q_sat, 1);
    check_val("sat_sticky_ovf", ovf_sat, 1);

    // Clear with a sample presented and two in flight: all of them dropped.
    drive(8'd2, 8'd2, 20'd1, 1'b0);
    cycle();
    cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check_val("clr_q", q_def, 0);
    check_val("clr_ovf", ovf_def, 0);
    check_val("clr_valid", ov_def, 0);
    check_val("clr_sat_ovf", ovf_sat, 0);
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val($sformatf("clr_drop_%0d", k), ov_def, 0);
    end
    check_val("clr_hold_q", q_def, 0);

    // Signed mode: -3*4+5 = -7.
    do_clr();
    drive(8'hFD, 8'd4, 20'd5, 1'b0);
    cycle();
    check_val("sgn_valid", ov_sgn, 1);
    check_val("sgn_q", q_sgn, 32'hFFFF9);
    check_val("sgn_ovf", ovf_sgn, 0);
    idle();
    cycle();
    check_val("sgn_valid_off", ov_sgn, 0);
    cycle();
    check_val("uns_fd_valid", ov_def, 1);
    check_val("uns_fd_q", q_def, 32'h3F9);

    // Asynchronous reset mid-stream, then a fresh sample.
    for (int k = 0; k < 4; k++) begin
      drive(8'd3, 8'd5, 20'd7, 1'b1);
      cycle();
    end
    check_val("prerst_valid", ov_def, 1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_q", q_def, 0);
    check_val("arst_valid", ov_def, 0);
    check_val("arst_ovf", ovf_def, 0);
    check_val("arst_sgn_q", q_sgn, 0);
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val($sformatf("post_rst_idle_%0d", k), ov_def, 0);
    end
    drive(8'd2, 8'd3, 20'd4, 1'b0);
    cycle();
    idle();
    cycle();
    cycle();
    check_val("post_rst_valid", ov_def, 1);
    check_val("post_rst_q", q_def, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
